// File: rtl/mem_access_stage.sv
// MEM stage: word-organised data memory with byte/half/word loads and stores, wait-state stall handshake.
// Optional MEM_ALIGN_TRAP_EN: suppress misaligned accesses and flag them instead of force-aligning.
module mem_access_stage #(
  parameter int DM_DEPTH    = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        XM_valid,
  output logic        XM_ready,
  input  logic [31:0] XM_ALUout,
  input  logic [4:0]  XM_RD,
  input  logic        XM_lwFlag,
  input  logic        XM_swFlag,
  input  logic [1:0]  XM_size,
  input  logic        XM_unsigned,
  input  logic [31:0] XM_storeData,
  output logic        MW_valid,
  output logic [31:0] MW_ALUout,
  output logic [4:0]  MW_RD,
  output logic        MW_regWrite,
  output logic        mem_misalign
);
  // state | meaning
  // IDLE  | ready; non-memory ops and zero-wait accesses complete on the accept edge
  // BUSY  | latched load/store waiting out its wait states; executes when cnt_q == 1
  localparam int         IDX_W  = $clog2(DM_DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] r_addr_q, r_addr_d, r_sdata_q, r_sdata_d;
  logic [4:0]  r_rd_q, r_rd_d;
  logic        r_lw_q, r_lw_d, r_sw_q, r_sw_d, r_uns_q, r_uns_d;
  logic [1:0]  r_size_q, r_size_d;

  logic        valid_q, valid_d, regwrite_q, regwrite_d, misalign_q, misalign_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;

  logic [31:0] mem [DM_DEPTH];

  logic        accept, exec, is_ld, is_st, suppress, wr_en;
  logic [31:0] s_addr, s_sdata, addr_eff, rd_word, ld_data, wr_word;
  logic [4:0]  s_rd;
  logic        s_lw, s_sw, s_uns;
  logic [1:0]  s_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [IDX_W-1:0] idx;

  assign XM_ready = (state_q == S_IDLE);
  assign accept   = XM_valid && XM_ready;

  always_comb begin
    // In BUSY the latched request executes; in IDLE the live inputs do.
    s_addr  = (state_q == S_BUSY) ? r_addr_q  : XM_ALUout;
    s_sdata = (state_q == S_BUSY) ? r_sdata_q : XM_storeData;
    s_rd    = (state_q == S_BUSY) ? r_rd_q    : XM_RD;
    s_lw    = (state_q == S_BUSY) ? r_lw_q    : XM_lwFlag;
    s_sw    = (state_q == S_BUSY) ? r_sw_q    : XM_swFlag;
    s_size  = (state_q == S_BUSY) ? r_size_q  : XM_size;
    s_uns   = (state_q == S_BUSY) ? r_uns_q   : XM_unsigned;

    exec = (accept && (!(XM_lwFlag || XM_swFlag) || WAIT_L == 4'd0)) ||
           (state_q == S_BUSY && cnt_q == 4'd1);
    is_ld = s_lw;
    is_st = s_sw && !s_lw;

`ifdef MEM_ALIGN_TRAP_EN
    addr_eff = s_addr;
    suppress = (is_ld || is_st) &&
               ((s_size == 2'b01 && s_addr[0]) || (s_size[1] && s_addr[1:0] != 2'b00));
`else
    addr_eff = s_addr;
    if (s_size == 2'b01) addr_eff[0] = 1'b0;
    else if (s_size[1])  addr_eff[1:0] = 2'b00;
    suppress = 1'b0;
`endif

    idx     = addr_eff[IDX_W+1:2];
    rd_word = mem[idx];
    ld_byte = rd_word[{addr_eff[1:0], 3'b000} +: 8];
    ld_half = addr_eff[1] ? rd_word[31:16] : rd_word[15:0];
    case (s_size)
      2'b00:   ld_data = s_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = s_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase

    wr_word = rd_word;
    case (s_size)
      2'b00:   wr_word[{addr_eff[1:0], 3'b000} +: 8] = s_sdata[7:0];
      2'b01:   wr_word[{addr_eff[1], 4'b0000} +: 16] = s_sdata[15:0];
      default: wr_word = s_sdata;
    endcase
    wr_en = exec && is_st && !suppress && !rst;

    valid_d    = exec;
    misalign_d = exec && suppress;
    regwrite_d = 1'b0;
    alu_d      = alu_q;
    rd_d       = rd_q;
    if (exec) begin
      if (suppress) begin
        alu_d = 32'h0;
        rd_d  = 5'd0;
      end else if (is_ld) begin
        alu_d      = ld_data;
        rd_d       = s_rd;
        regwrite_d = 1'b1;
      end else if (is_st) begin
        alu_d = addr_eff;
        rd_d  = 5'd0;
      end else begin
        alu_d      = s_addr;
        rd_d       = s_rd;
        regwrite_d = (s_rd != 5'd0);
      end
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    r_addr_d  = r_addr_q;
    r_sdata_d = r_sdata_q;
    r_rd_d    = r_rd_q;
    r_lw_d    = r_lw_q;
    r_sw_d    = r_sw_q;
    r_size_d  = r_size_q;
    r_uns_d   = r_uns_q;
    if (state_q == S_IDLE) begin
      if (accept && (XM_lwFlag || XM_swFlag) && WAIT_L != 4'd0) begin
        state_d   = S_BUSY;
        cnt_d     = WAIT_L;
        r_addr_d  = XM_ALUout;
        r_sdata_d = XM_storeData;
        r_rd_d    = XM_RD;
        r_lw_d    = XM_lwFlag;
        r_sw_d    = XM_swFlag;
        r_size_d  = XM_size;
        r_uns_d   = XM_unsigned;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      r_addr_q   <= 32'h0;
      r_sdata_q  <= 32'h0;
      r_rd_q     <= 5'd0;
      r_lw_q     <= 1'b0;
      r_sw_q     <= 1'b0;
      r_size_q   <= 2'b00;
      r_uns_q    <= 1'b0;
      valid_q    <= 1'b0;
      alu_q      <= 32'h0;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_addr_q   <= r_addr_d;
      r_sdata_q  <= r_sdata_d;
      r_rd_q     <= r_rd_d;
      r_lw_q     <= r_lw_d;
      r_sw_q     <= r_sw_d;
      r_size_q   <= r_size_d;
      r_uns_q    <= r_uns_d;
      valid_q    <= valid_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      misalign_q <= misalign_d;
    end
  end

  // Memory is deliberately unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wr_word;
  end

  assign MW_valid     = valid_q;
  assign MW_ALUout    = alu_q;
  assign MW_RD        = rd_q;
  assign MW_regWrite  = regwrite_q;
  assign mem_misalign = misalign_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: instance 0 has no wait states, instance 1 has three.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst    [2];
  logic        xv     [2];
  logic        xready [2];
  logic [31:0] xalu   [2];
  logic [4:0]  xrd    [2];
  logic        xlw    [2];
  logic        xsw    [2];
  logic [1:0]  xsz    [2];
  logic        xun    [2];
  logic [31:0] xsd    [2];
  logic        mv     [2];
  logic [31:0] malu   [2];
  logic [4:0]  mrd    [2];
  logic        mrw    [2];
  logic        mmis   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DM_DEPTH(128), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst[0]), .XM_valid(xv[0]), .XM_ready(xready[0]),
    .XM_ALUout(xalu[0]), .XM_RD(xrd[0]), .XM_lwFlag(xlw[0]), .XM_swFlag(xsw[0]),
    .XM_size(xsz[0]), .XM_unsigned(xun[0]), .XM_storeData(xsd[0]),
    .MW_valid(mv[0]), .MW_ALUout(malu[0]), .MW_RD(mrd[0]), .MW_regWrite(mrw[0]),
    .mem_misalign(mmis[0]));

  mem_access_stage #(.DM_DEPTH(128), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst[1]), .XM_valid(xv[1]), .XM_ready(xready[1]),
    .XM_ALUout(xalu[1]), .XM_RD(xrd[1]), .XM_lwFlag(xlw[1]), .XM_swFlag(xsw[1]),
    .XM_size(xsz[1]), .XM_unsigned(xun[1]), .XM_storeData(xsd[1]),
    .MW_valid(mv[1]), .MW_ALUout(malu[1]), .MW_RD(mrd[1]), .MW_regWrite(mrw[1]),
    .mem_misalign(mmis[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mw(input int d, input string tag, input logic v, input logic [31:0] a,
                        input logic [4:0] r, input logic rw, input logic mis);
    chk({tag, ".valid"}, 32'(mv[d]), 32'(v));
    chk({tag, ".alu"}, malu[d], a);
    chk({tag, ".rd"}, 32'(mrd[d]), 32'(r));
    chk({tag, ".rw"}, 32'(mrw[d]), 32'(rw));
    chk({tag, ".mis"}, 32'(mmis[d]), 32'(mis));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns 1 time unit after the accept edge.
  task automatic op(input int d, input logic lw, input logic sw, input logic [1:0] sz,
                    input logic un, input logic [31:0] a, input logic [4:0] r,
                    input logic [31:0] sd);
    xv[d] = 1'b1; xlw[d] = lw; xsw[d] = sw; xsz[d] = sz; xun[d] = un;
    xalu[d] = a; xrd[d] = r; xsd[d] = sd;
    step();
    xv[d] = 1'b0; xlw[d] = 1'b0; xsw[d] = 1'b0; xalu[d] = 32'hFFFF_FFFF;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; xv[d] = 1'b0; xalu[d] = '0; xrd[d] = '0; xlw[d] = 1'b0;
      xsw[d] = 1'b0; xsz[d] = 2'b00; xun[d] = 1'b0; xsd[d] = '0;
    end
    #1;
    chk("rst_ready0", 32'(xready[0]), 32'd1);
    chk("rst_ready1", 32'(xready[1]), 32'd1);
    step();
    chk_mw(0, "rst0", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk_mw(1, "rst1", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;

    // zero wait states: sw then lw, each completes on its accept edge
    op(0, 0, 1, 2'b10, 0, 32'h10, 5'd4, 32'hDEADBEEF);
    chk_mw(0, "sw10", 1'b1, 32'h10, 5'd0, 1'b0, 1'b0);
    op(0, 1, 0, 2'b10, 0, 32'h10, 5'd5, 32'h0);
    chk_mw(0, "lw10", 1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0);
    step();
    chk_mw(0, "idle", 1'b0, 32'hDEADBEEF, 5'd5, 1'b0, 1'b0);

    // byte lanes
    op(0, 0, 1, 2'b10, 0, 32'h10, 5'd0, 32'h11223344);
    op(0, 0, 1, 2'b00, 0, 32'h13, 5'd0, 32'hAAAA_AA80);
    op(0, 1, 0, 2'b00, 0, 32'h13, 5'd1, 32'h0);
    chk("lb13", malu[0], 32'hFFFFFF80);
    op(0, 1, 0, 2'b00, 1, 32'h13, 5'd1, 32'h0);
    chk("lbu13", malu[0], 32'h00000080);
    op(0, 1, 0, 2'b01, 1, 32'h12, 5'd2, 32'h0);
    chk("lhu12", malu[0], 32'h00008022);
    op(0, 1, 0, 2'b01, 0, 32'h12, 5'd2, 32'h0);
    chk("lh12", malu[0], 32'hFFFF8022);
    op(0, 1, 0, 2'b00, 0, 32'h10, 5'd2, 32'h0);
    chk("lb10", malu[0], 32'h00000044);
    op(0, 0, 1, 2'b01, 0, 32'h10, 5'd0, 32'hFFFF_BEEF);
    op(0, 1, 0, 2'b10, 0, 32'h10, 5'd6, 32'h0);
    chk_mw(0, "lw10b", 1'b1, 32'h8022BEEF, 5'd6, 1'b1, 1'b0);

    // address wrap modulo 4*DM_DEPTH
    op(0, 0, 1, 2'b10, 0, 32'h204, 5'd0, 32'h55);
    op(0, 1, 0, 2'b10, 0, 32'h004, 5'd7, 32'h0);
    chk("wrap", malu[0], 32'h00000055);

    // misaligned word load
    op(0, 0, 1, 2'b10, 0, 32'h20, 5'd0, 32'hCAFEF00D);
    op(0, 1, 0, 2'b10, 0, 32'h22, 5'd7, 32'h0);
`ifdef MEM_ALIGN_TRAP_EN
    chk_mw(0, "mis22", 1'b1, 32'h0, 5'd0, 1'b0, 1'b1);
`else
    chk_mw(0, "mis22", 1'b1, 32'hCAFEF00D, 5'd7, 1'b1, 1'b0);
`endif
    // lw+sw together behaves as a load and must not write
    op(0, 1, 1, 2'b10, 0, 32'h20, 5'd8, 32'h0);
    chk_mw(0, "lwsw", 1'b1, 32'hCAFEF00D, 5'd8, 1'b1, 1'b0);
    op(0, 1, 0, 2'b10, 0, 32'h20, 5'd8, 32'h0);
    chk("lw20", malu[0], 32'hCAFEF00D);

    // pass-through ALU ops
    op(0, 0, 0, 2'b10, 0, 32'h12345678, 5'd9, 32'h0);
    chk_mw(0, "alu9", 1'b1, 32'h12345678, 5'd9, 1'b1, 1'b0);
    op(0, 0, 0, 2'b10, 0, 32'h9ABCDEF0, 5'd0, 32'h0);
    chk_mw(0, "alu0", 1'b1, 32'h9ABCDEF0, 5'd0, 1'b0, 1'b0);

    // three wait states: sw 0 @0x40
    op(1, 0, 1, 2'b10, 0, 32'h40, 5'd0, 32'h0);
    chk("w3_sw_rdy0", 32'(xready[1]), 32'd0);
    step(); step(); step();
    chk_mw(1, "w3_sw", 1'b1, 32'h40, 5'd0, 1'b0, 1'b0);

    // lw: ready low for exactly three cycles, MW update on the fourth edge
    op(1, 1, 0, 2'b10, 0, 32'h40, 5'd3, 32'h0);
    chk("w3_rdy_e0", 32'(xready[1]), 32'd0);
    chk("w3_v_e0", 32'(mv[1]), 32'd0);
    step();
    chk("w3_rdy_e1", 32'(xready[1]), 32'd0);
    chk("w3_v_e1", 32'(mv[1]), 32'd0);
    step();
    chk("w3_rdy_e2", 32'(xready[1]), 32'd0);
    chk("w3_v_e2", 32'(mv[1]), 32'd0);
    step();
    chk("w3_rdy_e3", 32'(xready[1]), 32'd1);
    chk_mw(1, "w3_lw", 1'b1, 32'h0, 5'd3, 1'b1, 1'b0);
    op(1, 0, 0, 2'b10, 0, 32'hA5A5A5A5, 5'd10, 32'h0);
    chk_mw(1, "w3_alu1", 1'b1, 32'hA5A5A5A5, 5'd10, 1'b1, 1'b0);
    op(1, 0, 0, 2'b10, 0, 32'h5A5A5A5A, 5'd11, 32'h0);
    chk_mw(1, "w3_alu2", 1'b1, 32'h5A5A5A5A, 5'd11, 1'b1, 1'b0);

    // reset mid-BUSY aborts a pending store
    op(1, 0, 1, 2'b10, 0, 32'h40, 5'd0, 32'h1234);
    step();
    rst[1] = 1'b1;
    #1;
    chk("abort_rdy", 32'(xready[1]), 32'd1);
    chk("abort_v", 32'(mv[1]), 32'd0);
    step();
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    op(1, 1, 0, 2'b10, 0, 32'h40, 5'd3, 32'h0);
    step(); step(); step();
    chk_mw(1, "abort_lw", 1'b1, 32'h0, 5'd3, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
